palu_muldiv: RTL and testbench

Parametrised execute-stage ALU for the pipelined CPU: operand forwarding muxes, a single-cycle arithmetic/logic path and an iterative multiply/divide unit with HI/LO registers. While a multiply or divide runs, it stalls the pipeline through `out_lock`. It sits between the ID/EX and EX/MEM pipeline registers. The forwarding selects come from the hazard unit.

---
 rtl/palu_pkg.sv | 56 +++++
 rtl/palu_muldiv_if.sv | 35 +++
 rtl/palu_md_core.sv | 162 ++++++++++++++++
 rtl/palu_muldiv.sv | 84 ++++++++
 tb/tb_palu_muldiv.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/palu_pkg.sv
// Shared opcodes, FSM state type and operand-select priority encoders for palu_muldiv.
package palu_pkg;

    localparam logic [3:0] AluOpSll  = 4'd0;
    localparam logic [3:0] AluOpSra  = 4'd1;
    localparam logic [3:0] AluOpSrl  = 4'd2;
    localparam logic [3:0] AluOpAdd  = 4'd5;
    localparam logic [3:0] AluOpSub  = 4'd6;
    localparam logic [3:0] AluOpAnd  = 4'd7;
    localparam logic [3:0] AluOpOr   = 4'd8;
    localparam logic [3:0] AluOpXor  = 4'd9;
    localparam logic [3:0] AluOpNor  = 4'd10;
    localparam logic [3:0] AluOpSlt  = 4'd11;
    localparam logic [3:0] AluOpSltu = 4'd12;

    localparam logic [2:0] MdNone  = 3'd0;
    localparam logic [2:0] MdMult  = 3'd1;
    localparam logic [2:0] MdMultu = 3'd2;
    localparam logic [2:0] MdDiv   = 3'd3;
    localparam logic [2:0] MdDivu  = 3'd4;
    localparam logic [2:0] MdMfhi  = 3'd5;
    localparam logic [2:0] MdMflo  = 3'd6;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

    typedef enum logic [1:0] {XSelA, XSelB, XSelR, XSelWb} x_sel_e;

    typedef enum logic [2:0] {
        YSelP1, YSelExt, YSelB, YSelA, YSelZero, YSelR, YSelWb
    } y_sel_e;

    function automatic x_sel_e palu_x_sel(input logic fwd_wb, input logic fwd_r,
                                          input logic use_b);
        x_sel_e sel;
        if (fwd_wb)     sel = XSelWb;
        else if (fwd_r) sel = XSelR;
        else if (use_b) sel = XSelB;
        else            sel = XSelA;
        return sel;
    endfunction

    function automatic y_sel_e palu_y_sel(input logic fwd_wb, input logic fwd_r,
                                          input logic zero, input logic use_a,
                                          input logic use_b, input logic use_ext);
        y_sel_e sel;
        if (fwd_wb)       sel = YSelWb;
        else if (fwd_r)   sel = YSelR;
        else if (zero)    sel = YSelZero;
        else if (use_a)   sel = YSelA;
        else if (use_b)   sel = YSelB;
        else if (use_ext) sel = YSelExt;
        else              sel = YSelP1;
        return sel;
    endfunction

endpackage

// File: rtl/palu_muldiv_if.sv
// Execute-stage operand/result bundle between the pipeline and palu_muldiv.
interface palu_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic [3:0]       in_ALUOP;
    logic [2:0]       in_MDOP;
    logic [3:0]       in_ALUIN;
    logic [3:0]       in_ALUREDI;
    logic             in_BGEZ;
    logic [WIDTH-1:0] in_A;
    logic [WIDTH-1:0] in_B;
    logic [WIDTH-1:0] in_R;
    logic [WIDTH-1:0] in_WB;
    logic [WIDTH-1:0] in_extended;
    logic [WIDTH-1:0] in_p1;
    logic [WIDTH-1:0] out_R;
    logic             out_result;
    logic             out_equal;
    logic             out_lock;
    logic [WIDTH-1:0] out_HI;
    logic [WIDTH-1:0] out_LO;

    modport master (
        output in_ALUOP, in_MDOP, in_ALUIN, in_ALUREDI, in_BGEZ,
        output in_A, in_B, in_R, in_WB, in_extended, in_p1,
        input  out_R, out_result, out_equal, out_lock, out_HI, out_LO
    );

    modport slave (
        input  in_ALUOP, in_MDOP, in_ALUIN, in_ALUREDI, in_BGEZ,
        input  in_A, in_B, in_R, in_WB, in_extended, in_p1,
        output out_R, out_result, out_equal, out_lock, out_HI, out_LO
    );

endinterface

// File: rtl/palu_md_core.sv
// Iterative shift-add multiplier / restoring divider with HI/LO, one bit per cycle.
// Divide support is built only when PALU_DIV_EN is defined.
module palu_md_core
    import palu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [2:0]       mdop_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic             lock_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int unsigned CntW = $clog2(WIDTH);

    md_state_e          state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    // acc: product upper half / partial remainder; ql: multiplier / dividend -> quotient
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   ql_q, ql_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               start_mul, start_div, start_signed, start;
    logic [WIDTH-1:0]   x_mag, y_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   step_acc, step_ql, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        start_mul = (mdop_i == MdMult) || (mdop_i == MdMultu);
`ifdef PALU_DIV_EN
        start_div = (mdop_i == MdDiv) || (mdop_i == MdDivu);
`else
        start_div = 1'b0;
`endif
        start_signed = (mdop_i == MdMult) || (mdop_i == MdDiv);
        start        = start_mul || start_div;
        x_mag        = (start_signed && x_i[WIDTH-1]) ? -x_i : x_i;
        y_mag        = (start_signed && y_i[WIDTH-1]) ? -y_i : y_i;
    end

`ifdef PALU_DIV_EN
    logic               is_div_q, rneg_q, dz_q;
    logic [WIDTH-1:0]   dvd_q;
    logic [WIDTH:0]     div_shift, div_trial;

    // Divide-specific flags only change when a new operation is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            is_div_q <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            dvd_q    <= '0;
        end else if (state_q == StIdle && start) begin
            is_div_q <= start_div;
            rneg_q   <= start_signed && x_i[WIDTH-1];
            dz_q     <= (y_i == '0);
            dvd_q    <= x_i;
        end
    end
`endif

    always_comb begin
        mul_sum  = {1'b0, acc_q} + (ql_q[0] ? {1'b0, opnd_q} : '0);
        step_acc = mul_sum[WIDTH:1];
        step_ql  = {mul_sum[0], ql_q[WIDTH-1:1]};
        prod     = {step_acc, step_ql};
        if (neg_q) prod = -prod;
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
`ifdef PALU_DIV_EN
        div_shift = {acc_q, ql_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        if (is_div_q) begin
            // Borrow out of the trial subtraction means restore.
            if (div_trial[WIDTH]) begin
                step_acc = div_shift[WIDTH-1:0];
                step_ql  = {ql_q[WIDTH-2:0], 1'b0};
            end else begin
                step_acc = div_trial[WIDTH-1:0];
                step_ql  = {ql_q[WIDTH-2:0], 1'b1};
            end
            fix_lo = neg_q ? -step_ql : step_ql;
            fix_hi = rneg_q ? -step_acc : step_acc;
            if (dz_q) begin
                fix_lo = '1;
                fix_hi = dvd_q;
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ql_d    = ql_q;
        opnd_d  = opnd_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        lock_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    lock_o  = 1'b1;
                    state_d = StBusy;
                    cnt_d   = CntW'(WIDTH - 1);
                    acc_d   = '0;
                    ql_d    = x_mag;
                    opnd_d  = y_mag;
                    neg_d   = start_signed && (x_i[WIDTH-1] ^ y_i[WIDTH-1]);
                end
            end
            StBusy: begin
                lock_o = 1'b1;
                acc_d  = step_acc;
                ql_d   = step_ql;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    hi_d    = fix_hi;
                    lo_d    = fix_lo;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            ql_q    <= '0;
            opnd_q  <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ql_q    <= ql_d;
            opnd_q  <= opnd_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/palu_muldiv.sv
// Execute-stage ALU: forwarding muxes, single-cycle ALU and iterative mul/div (palu_md_core).
// Define PALU_DIV_EN to build DIV/DIVU support.
module palu_muldiv
    import palu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic          in_CLK,
    input logic          in_RST,
    palu_muldiv_if.slave bus
);
    localparam int unsigned ShW = $clog2(WIDTH);

    x_sel_e           x_sel;
    y_sel_e           y_sel;
    logic [WIDTH-1:0] x, y, alu, res, hi, lo;
    logic [ShW-1:0]   shamt;
    logic             lock;

    always_comb begin
        x_sel = palu_x_sel(bus.in_ALUREDI[2], bus.in_ALUREDI[0], bus.in_ALUIN[0]);
        y_sel = palu_y_sel(bus.in_ALUREDI[3], bus.in_ALUREDI[1], bus.in_BGEZ,
                           bus.in_ALUIN[1], bus.in_ALUIN[2], bus.in_ALUIN[3]);
        unique case (x_sel)
            XSelWb:  x = bus.in_WB;
            XSelR:   x = bus.in_R;
            XSelB:   x = bus.in_B;
            default: x = bus.in_A;
        endcase
        case (y_sel)
            YSelWb:   y = bus.in_WB;
            YSelR:    y = bus.in_R;
            YSelZero: y = '0;
            YSelA:    y = bus.in_A;
            YSelB:    y = bus.in_B;
            YSelExt:  y = bus.in_extended;
            default:  y = bus.in_p1;
        endcase
    end

    always_comb begin
        shamt = y[ShW-1:0];
        case (bus.in_ALUOP)
            AluOpSll:  alu = x << shamt;
            AluOpSra:  alu = $signed(x) >>> shamt;
            AluOpSrl:  alu = x >> shamt;
            AluOpAdd:  alu = x + y;
            AluOpSub:  alu = x - y;
            AluOpAnd:  alu = x & y;
            AluOpOr:   alu = x | y;
            AluOpXor:  alu = x ^ y;
            AluOpNor:  alu = ~(x | y);
            AluOpSlt:  alu = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            AluOpSltu: alu = {{(WIDTH-1){1'b0}}, (x < y)};
            default:   alu = '0;
        endcase
        case (bus.in_MDOP)
            MdMfhi:  res = hi;
            MdMflo:  res = lo;
            default: res = alu;
        endcase
    end

    palu_md_core #(
        .WIDTH (WIDTH)
    ) u_md_core (
        .clk_i  (in_CLK),
        .rst_i  (in_RST),
        .mdop_i (bus.in_MDOP),
        .x_i    (x),
        .y_i    (y),
        .lock_o (lock),
        .hi_o   (hi),
        .lo_o   (lo)
    );

    assign bus.out_R      = res;
    assign bus.out_result = res[0];
    assign bus.out_equal  = (x == y);
    assign bus.out_lock   = lock;
    assign bus.out_HI     = hi;
    assign bus.out_LO     = lo;

endmodule

// File: tb/tb_palu_muldiv.sv
// Self-checking bench for palu_muldiv: ALU vector table plus mul/div scoreboard sequences.
module tb_palu_muldiv;
    import palu_pkg::*;

    localparam int unsigned W = 32;

    typedef struct {
        string        name;
        logic [3:0]   aluop;
        logic [2:0]   mdop;
        logic [3:0]   aluin;
        logic [3:0]   aluredi;
        logic         bgez;
        logic [W-1:0] a, b, r, wb, ext, p1;
        logic [W-1:0] exp_r;
        logic         exp_eq;
    } vec_t;

    typedef struct {
        string        name;
        logic [W-1:0] r;
        logic         eq;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lock_cycles;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    palu_muldiv_if #(.WIDTH(W)) bus ();

    palu_muldiv #(.WIDTH(W)) dut (
        .in_CLK (clk),
        .in_RST (rst),
        .bus    (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no end of test, required end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [3:0] aluop,
                                input logic [2:0] mdop, input logic [3:0] aluin,
                                input logic [3:0] aluredi, input logic bgez,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] r, input logic [W-1:0] wb,
                                input logic [W-1:0] ext, input logic [W-1:0] p1,
                                input logic [W-1:0] exp_r, input logic exp_eq);
        vec_t v;
        v.name = name; v.aluop = aluop; v.mdop = mdop; v.aluin = aluin;
        v.aluredi = aluredi; v.bgez = bgez; v.a = a; v.b = b; v.r = r; v.wb = wb;
        v.ext = ext; v.p1 = p1; v.exp_r = exp_r; v.exp_eq = exp_eq;
        return v;
    endfunction

    function automatic logic [2*W-1:0] mul_model(input logic sgn, input logic [W-1:0] x,
                                                 input logic [W-1:0] y);
        longint          sx, sy;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = 64'(x);
        uy = 64'(y);
        return sgn ? 64'(sx * sy) : ux * uy;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.in_ALUOP = '0; bus.in_MDOP = MdNone; bus.in_ALUIN = '0; bus.in_ALUREDI = '0;
        bus.in_BGEZ = 1'b0; bus.in_A = '0; bus.in_B = '0; bus.in_R = '0; bus.in_WB = '0;
        bus.in_extended = '0; bus.in_p1 = '0;
    endtask

    // X = A, Y = B
    task automatic drive_md(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        clear_inputs();
        bus.in_ALUOP = AluOpAdd;
        bus.in_ALUIN = 4'b0100;
        bus.in_A     = x;
        bus.in_B     = y;
        bus.in_MDOP  = op;
    endtask

    task automatic push_md(input string name, input logic [W-1:0] hi, input logic [W-1:0] lo,
                           input int lock_cycles);
        exp_t e;
        e.name = name; e.r = '0; e.eq = 1'b0; e.hi = hi; e.lo = lo; e.lock_cycles = lock_cycles;
        sb.push_back(e);
    endtask

    // Called in the start cycle before its negedge; returns at the negedge of the DONE cycle.
    task automatic wait_done();
        exp_t e;
        int   cycles = 0;
        @(negedge clk);
        while (bus.out_lock === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        e = sb.pop_front();
        check({e.name, "_lock_cycles"}, cycles, e.lock_cycles);
        check({e.name, "_hi"}, bus.out_HI, e.hi);
        check({e.name, "_lo"}, bus.out_LO, e.lo);
    endtask

    task automatic run_md(input string name, input logic [2:0] op, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] hi, input logic [W-1:0] lo,
                          input int lock_cycles);
        next_cycle();
        drive_md(op, x, y);
        push_md(name, hi, lo, lock_cycles);
        wait_done();
    endtask

    task automatic check_mfx(input string name, input logic [2:0] op, input logic [W-1:0] exp);
        next_cycle();
        clear_inputs();
        bus.in_MDOP = op;
        bus.in_A    = 32'h1;
        bus.in_p1   = 32'h2;
        @(negedge clk);
        check(name, bus.out_R, exp);
    endtask

    initial begin
        logic [W-1:0]   rx, ry;
        logic [2*W-1:0] rp;
        exp_t           e;
        int             lock_seen;

        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_lock", bus.out_lock, 1'b0);
        check("reset_hi", bus.out_HI, '0);
        check("reset_lo", bus.out_LO, '0);

        vecs.push_back(mk("fwd_wb",   AluOpAdd, MdNone, 4'b0000, 4'b0101, 0, 0, 0, 9, 7, 0, 1, 8, 0));
        vecs.push_back(mk("fwd_b",    AluOpAdd, MdNone, 4'b0001, 4'b0000, 0, 0, 3, 9, 7, 0, 1, 4, 0));
        vecs.push_back(mk("sll",      AluOpSll, MdNone, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 0, 4, 16, 0));
        vecs.push_back(mk("sra",      AluOpSra, MdNone, 4'b0000, 4'b0000, 0, 32'h8000_0000, 0, 0, 0,
                          0, 4, 32'hF800_0000, 0));
        vecs.push_back(mk("srl",      AluOpSrl, MdNone, 4'b0000, 4'b0000, 0, 32'h8000_0000, 0, 0, 0,
                          0, 4, 32'h0800_0000, 0));
        vecs.push_back(mk("sll_mask", AluOpSll, MdNone, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 0, 32'h25,
                          32'h20, 0));
        vecs.push_back(mk("sub_ext",  AluOpSub, MdNone, 4'b1000, 4'b0000, 0, 5, 0, 0, 0, 7, 1,
                          32'hFFFF_FFFE, 0));
        vecs.push_back(mk("and",      AluOpAnd, MdNone, 4'b0100, 4'b0000, 0, 32'hF0F0_F0F0,
                          32'hFF00_FF00, 0, 0, 0, 0, 32'hF000_F000, 0));
        vecs.push_back(mk("or",       AluOpOr,  MdNone, 4'b0100, 4'b0000, 0, 32'hF0F0_F0F0,
                          32'hFF00_FF00, 0, 0, 0, 0, 32'hFFF0_FFF0, 0));
        vecs.push_back(mk("xor",      AluOpXor, MdNone, 4'b0100, 4'b0000, 0, 32'hF0F0_F0F0,
                          32'hFF00_FF00, 0, 0, 0, 0, 32'h0FF0_0FF0, 0));
        vecs.push_back(mk("nor",      AluOpNor, MdNone, 4'b0100, 4'b0000, 0, 32'hF0F0_F0F0,
                          32'hFF00_FF00, 0, 0, 0, 0, 32'h000F_000F, 0));
        vecs.push_back(mk("slt_neg",  AluOpSlt, MdNone, 4'b0000, 4'b0000, 0, 32'hFFFF_FFFF, 0, 0, 0,
                          0, 1, 1, 0));
        vecs.push_back(mk("sltu_neg", AluOpSltu, MdNone, 4'b0000, 4'b0000, 0, 32'hFFFF_FFFF, 0, 0,
                          0, 0, 1, 0, 0));
        vecs.push_back(mk("slt_pos",  AluOpSlt, MdNone, 4'b0000, 4'b0000, 0, 32'h7FFF_FFFF, 0, 0, 0,
                          0, 32'h8000_0000, 0, 0));
        vecs.push_back(mk("sltu_pos", AluOpSltu, MdNone, 4'b0000, 4'b0000, 0, 32'h7FFF_FFFF, 0, 0,
                          0, 0, 32'h8000_0000, 1, 0));
        vecs.push_back(mk("op4_zero", 4'd4, MdNone, 4'b0000, 4'b0000, 0, 5, 0, 0, 0, 0, 6, 0, 0));
        vecs.push_back(mk("op15_zero", 4'd15, MdNone, 4'b0000, 4'b0000, 0, 5, 0, 0, 0, 0, 6, 0, 0));
        vecs.push_back(mk("bgez",     AluOpAdd, MdNone, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0, 3, 0, 1));
        vecs.push_back(mk("y_a",      AluOpSub, MdNone, 4'b1110, 4'b0000, 0, 6, 100, 0, 0, 200, 1,
                          0, 1));
        vecs.push_back(mk("y_wb",     AluOpAdd, MdNone, 4'b0000, 4'b1010, 0, 1, 0, 20, 10, 0, 0,
                          11, 0));
        vecs.push_back(mk("y_r",      AluOpSub, MdNone, 4'b0000, 4'b0010, 1, 1, 0, 20, 10, 0, 0,
                          32'hFFFF_FFED, 0));
        vecs.push_back(mk("add_wrap", AluOpAdd, MdNone, 4'b0000, 4'b0000, 0, 32'hFFFF_FFFF, 0, 0, 0,
                          0, 2, 1, 0));
        vecs.push_back(mk("x_r",      AluOpXor, MdNone, 4'b0001, 4'b0001, 0, 0, 32'h99, 32'h10, 0,
                          0, 32'h10, 0, 1));
        vecs.push_back(mk("x_b_y_b",  AluOpAdd, MdNone, 4'b0101, 4'b0000, 0, 2, 9, 0, 0, 0, 0,
                          18, 1));
        vecs.push_back(mk("mfhi_rst", AluOpAdd, MdMfhi, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mk("mflo_rst", AluOpAdd, MdMflo, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 0, 2, 0, 0));

        foreach (vecs[i]) begin
            next_cycle();
            bus.in_ALUOP = vecs[i].aluop; bus.in_MDOP = vecs[i].mdop;
            bus.in_ALUIN = vecs[i].aluin; bus.in_ALUREDI = vecs[i].aluredi;
            bus.in_BGEZ = vecs[i].bgez; bus.in_A = vecs[i].a; bus.in_B = vecs[i].b;
            bus.in_R = vecs[i].r; bus.in_WB = vecs[i].wb; bus.in_extended = vecs[i].ext;
            bus.in_p1 = vecs[i].p1;
            e.name = vecs[i].name; e.r = vecs[i].exp_r; e.eq = vecs[i].exp_eq;
            e.hi = '0; e.lo = '0; e.lock_cycles = 0;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            check({e.name, "_R"}, bus.out_R, e.r);
            check({e.name, "_result"}, bus.out_result, e.r[0]);
            check({e.name, "_equal"}, bus.out_equal, e.eq);
            check({e.name, "_lock"}, bus.out_lock, 1'b0);
        end

        // Signed multiply, then HI/LO readback through the result mux.
        run_md("mult_neg", MdMult, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
        check_mfx("mflo_after_mult", MdMflo, 32'hFFFF_FFF1);
        check_mfx("mfhi_after_mult", MdMfhi, 32'hFFFF_FFFF);

        // Reset in the 10th BUSY cycle with MDOP dropped.
        next_cycle();
        drive_md(MdMultu, 32'd123456, 32'd789);
        @(negedge clk);
        check("rst_mid_start_lock", bus.out_lock, 1'b1);
        repeat (10) next_cycle();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy_lock", bus.out_lock, 1'b1);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_lock", bus.out_lock, 1'b0);
        check("rst_mid_hi", bus.out_HI, '0);
        check("rst_mid_lo", bus.out_LO, '0);
        next_cycle();
        @(negedge clk);
        check("rst_mid_idle_lock", bus.out_lock, 1'b0);

        // Reset while MDOP stays presented: a fresh operation starts right after.
        next_cycle();
        drive_md(MdMultu, 32'd1000, 32'd1000);
        repeat (5) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        push_md("rst_restart", 32'd0, 32'd1000000, 33);
        wait_done();

        for (int i = 0; i < 4; i++) begin
            rx = $urandom;
            ry = $urandom;
            rp = mul_model(i[0], rx, ry);
            run_md(i[0] ? "rand_mult" : "rand_multu", i[0] ? MdMult : MdMultu, rx, ry,
                   rp[2*W-1:W], rp[W-1:0], 33);
        end

        // Back-to-back: the second operation must start in the IDLE cycle right after DONE.
        run_md("b2b_multu", MdMultu, 32'd2, 32'd3, 32'd0, 32'd6, 33);
`ifdef PALU_DIV_EN
        run_md("b2b_divu", MdDivu, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        run_md("div_neg", MdDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_md("divu_zero", MdDivu, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 33);
        run_md("div_zero_neg", MdDiv, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 33);
        run_md("div_min_m1", MdDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
        run_md("div_negdivisor", MdDiv, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
        check_mfx("mflo_after_div", MdMflo, 32'hFFFF_FFFD);
        check_mfx("mfhi_after_div", MdMfhi, 32'd1);
`else
        // 3205 * 6700417 = 5 * 2^32 + 5 preloads HI = LO = 5.
        run_md("preload_55", MdMultu, 32'd3205, 32'd6700417, 32'd5, 32'd5, 33);
        next_cycle();
        drive_md(MdDiv, 32'd9, 32'd2);
        lock_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.out_lock !== 1'b0) lock_seen++;
            next_cycle();
            bus.in_MDOP = (c < 20) ? MdDiv : MdDivu;
        end
        check("div_off_lock_cycles", lock_seen, 0);
        @(negedge clk);
        check("div_off_hi", bus.out_HI, 32'd5);
        check("div_off_lo", bus.out_LO, 32'd5);
        check_mfx("mfhi_div_off", MdMfhi, 32'd5);
`endif

        next_cycle();
        clear_inputs();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
